// File: rtl/caxi4interconnect_fifo_pkg.sv
// Shared constants and parameter checks for the interconnect's synchronous FIFOs.
package caxi4interconnect_fifo_pkg;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int fifo_addr_width(input int depth);
    int a;
    a = $clog2(depth);
    return (a < 1) ? 1 : a;
  endfunction

  // Width of the fill-level count: must be able to hold the value 'depth' itself.
  function automatic int fifo_level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Legal configuration: power-of-two depth >= 2, thresholds inside the level range.
  function automatic bit fifo_params_ok(input int depth, input int afull, input int aempty);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return pow2 && (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/caxi4interconnect_RAM_BLOCK.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module caxi4interconnect_RAM_BLOCK #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/caxi4interconnect_sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides, a first-word-fall-through
// output register, fill level, almost flags and synchronous flush.
module caxi4interconnect_sync_fifo
  import caxi4interconnect_fifo_pkg::*;
#(
  parameter int MEM_DEPTH     = 4,
  parameter int DATA_WIDTH    = 20,
  parameter int AFULL_THRESH  = MEM_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      infoIn,
  input  logic                       infoInValid,
  output logic                       readyForInfo,
  output logic [DATA_WIDTH-1:0]      infoOut,
  output logic                       infoOutValid,
  input  logic                       readyForOut,
  output logic [$clog2(MEM_DEPTH):0] level,
  output logic                       almostFull,
  output logic                       almostEmpty
);

  localparam int AW = fifo_addr_width(MEM_DEPTH);
  localparam int LW = fifo_level_width(MEM_DEPTH);

  if (!fifo_params_ok(MEM_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("caxi4interconnect_sync_fifo: illegal MEM_DEPTH/threshold configuration");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  push, pop, load_head, ram_empty, ram_we;
  logic [LW-1:0]         level_next;

  // RAM pointers wrap over the MEM_DEPTH-1 RAM entries (the head register is the last slot).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MEM_DEPTH - 2)) ? '0 : p + AW'(1);
  endfunction

  // Handshakes, head-refill decision and next fill level.
  always_comb begin
    push       = infoInValid & readyForInfo;
    pop        = infoOutValid & readyForOut;
    // Head register can take a new entry when it is empty or leaving this cycle.
    load_head  = ~infoOutValid | readyForOut;
    // Entries in RAM = level minus the head entry.
    ram_empty  = (level == {{(LW-1){1'b0}}, infoOutValid});
    // A push goes to RAM unless it bypasses straight into an empty head.
    ram_we     = push & ~(load_head & ram_empty) & rst & ~flush;
    level_next = level + LW'(push) - LW'(pop);
  end

  caxi4interconnect_RAM_BLOCK #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (infoIn),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Pointers, output stage, level and registered status flags; reset and flush clear all.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      infoOut      <= '0;
      infoOutValid <= 1'b0;
      level        <= '0;
      readyForInfo <= 1'b1;
      almostFull   <= 1'b0;
      almostEmpty  <= 1'b1;
    end else begin
      if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
      if (load_head) begin
        if (!ram_empty) begin
          infoOut      <= ram_rdata;
          infoOutValid <= 1'b1;
          rd_ptr       <= ptr_inc(rd_ptr);
        end else if (push) begin
          infoOut      <= infoIn;
          infoOutValid <= 1'b1;
        end else begin
          infoOutValid <= 1'b0;
        end
      end
      level        <= level_next;
      readyForInfo <= (level_next < LW'(MEM_DEPTH));
      almostFull   <= (level_next >= LW'(AFULL_THRESH));
      almostEmpty  <= (level_next <= LW'(AEMPTY_THRESH));
    end
  end

endmodule

// File: tb/tb_caxi4interconnect_sync_fifo.sv
// Directed bench for caxi4interconnect_sync_fifo at MEM_DEPTH=4.
module tb_caxi4interconnect_sync_fifo;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [DW-1:0] infoIn;
  logic          infoInValid, readyForInfo;
  logic [DW-1:0] infoOut;
  logic          infoOutValid, readyForOut;
  logic [2:0]    level;
  logic          almostFull, almostEmpty;

  int n_vec = 0;
  int n_err = 0;

  caxi4interconnect_sync_fifo #(
    .MEM_DEPTH (4), .DATA_WIDTH (DW), .AFULL_THRESH (3), .AEMPTY_THRESH (1)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .infoIn (infoIn), .infoInValid (infoInValid), .readyForInfo (readyForInfo),
    .infoOut (infoOut), .infoOutValid (infoOutValid), .readyForOut (readyForOut),
    .level (level), .almostFull (almostFull), .almostEmpty (almostEmpty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [DW-1:0] d);
    infoIn = d; infoInValid = 1'b1; readyForOut = 1'b0;
    tick();
    infoInValid = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".level"}, 32'(level), 0);
    chk({tag, ".vld"},   32'(infoOutValid), 0);
    chk({tag, ".rdy"},   32'(readyForInfo), 1);
    chk({tag, ".ae"},    32'(almostEmpty), 1);
    chk({tag, ".af"},    32'(almostFull), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; infoIn = '0; infoInValid = 1'b0; readyForOut = 1'b0;
    #1;
    tick(); tick();
    chk_empty("reset");
    chk("reset.out", 32'(infoOut), 0);
    rst = 1'b1;

    // Fill with 1..4, nothing consumed.
    for (int i = 1; i <= 4; i++) begin
      chk("fill.rdy_before", 32'(readyForInfo), 1);
      push_n(DW'(i));
      chk("fill.level", 32'(level), 32'(i));
      chk("fill.af",    32'(almostFull), (i >= 3) ? 1 : 0);
      chk("fill.ae",    32'(almostEmpty), (i <= 1) ? 1 : 0);
    end
    chk("fill.rdy_full", 32'(readyForInfo), 0);
    chk("fill.head", 32'(infoOut), 1);
    push_n(DW'(5));
    chk("fill.5th_level", 32'(level), 4);
    chk("fill.head_stable", 32'(infoOut), 1);
    chk("fill.vld_stable", 32'(infoOutValid), 1);

    // Drain in order.
    readyForOut = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain.vld", 32'(infoOutValid), 1);
      chk("drain.data", 32'(infoOut), 32'(i));
      tick();
    end
    readyForOut = 1'b0;
    chk_empty("drain");

    // Bypass: push into empty with consumer ready.
    infoIn = DW'('hA5); infoInValid = 1'b1; readyForOut = 1'b1;
    tick();
    infoInValid = 1'b0;
    chk("byp.vld", 32'(infoOutValid), 1);
    chk("byp.data", 32'(infoOut), 32'h0A5);
    chk("byp.level1", 32'(level), 1);
    tick();
    readyForOut = 1'b0;
    chk("byp.level0", 32'(level), 0);
    chk("byp.vld0", 32'(infoOutValid), 0);

    // Streaming at level 2.
    push_n(DW'('h10));
    push_n(DW'('h11));
    chk("stream.level_start", 32'(level), 2);
    for (int k = 0; k < 20; k++) begin
      infoIn = DW'('h12 + k); infoInValid = 1'b1; readyForOut = 1'b1;
      chk("stream.vld", 32'(infoOutValid), 1);
      chk("stream.data", 32'(infoOut), 32'('h10 + k));
      tick();
      chk("stream.level", 32'(level), 2);
    end
    infoInValid = 1'b0; readyForOut = 1'b0;
    chk("stream.head_end", 32'(infoOut), 32'h24);

    // Full turnaround: hold a push while one pop frees a slot.
    push_n(DW'('h30));
    push_n(DW'('h31));
    chk("turn.full", 32'(readyForInfo), 0);
    infoIn = DW'('h32); infoInValid = 1'b1; readyForOut = 1'b1;
    tick();
    readyForOut = 1'b0;
    chk("turn.level3", 32'(level), 3);
    chk("turn.rdy", 32'(readyForInfo), 1);
    tick();
    infoInValid = 1'b0;
    chk("turn.level4", 32'(level), 4);
    chk("turn.rdy_low", 32'(readyForInfo), 0);
    chk("turn.head", 32'(infoOut), 32'h25);

    // Flush at level 3 together with push and pop.
    readyForOut = 1'b1;
    tick();
    chk("flush.pre_level", 32'(level), 3);
    chk("flush.pre_head", 32'(infoOut), 32'h30);
    flush = 1'b1; infoIn = DW'('h40); infoInValid = 1'b1; readyForOut = 1'b1;
    tick();
    flush = 1'b0; infoInValid = 1'b0; readyForOut = 1'b0;
    chk_empty("flush");
    tick();
    chk("flush.discard", 32'(level), 0);
    push_n(DW'('h41));
    chk("flush.after_head", 32'(infoOut), 32'h41);
    readyForOut = 1'b1;
    tick();
    readyForOut = 1'b0;

    // Same case with reset instead of flush.
    push_n(DW'('h50));
    push_n(DW'('h51));
    push_n(DW'('h52));
    chk("rst.pre_level", 32'(level), 3);
    rst = 1'b0; infoIn = DW'('h53); infoInValid = 1'b1; readyForOut = 1'b1;
    tick();
    rst = 1'b1; infoInValid = 1'b0; readyForOut = 1'b0;
    chk_empty("rst");
    tick();
    chk("rst.discard", 32'(level), 0);
    push_n(DW'('h60));
    chk("rst.after_head", 32'(infoOut), 32'h60);
    chk("rst.after_level", 32'(level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
